// File: rtl/jzjpcc_mem_arbiter_if.sv
// ============================================================================
// Module   : jzjpcc_mem_arbiter_if
// Brief    : Requester, RAM and status bundle for the memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jzjpcc_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  coreReq;
    logic                  coreWrite;
    logic [ADDR_WIDTH-1:0] coreAddr;
    logic [31:0]           coreWData;
    logic [3:0]            coreByteEn;
    logic                  coreGrant;
    logic                  coreStall;
    logic                  coreRValid;
    logic [31:0]           coreRData;

    logic                  dbgReq;
    logic                  dbgWrite;
    logic [ADDR_WIDTH-1:0] dbgAddr;
    logic [31:0]           dbgWData;
    logic [3:0]            dbgByteEn;
    logic                  dbgGrant;
    logic                  dbgRValid;
    logic [31:0]           dbgRData;

    logic                  ramEnable;
    logic                  ramWrite;
    logic [ADDR_WIDTH-1:0] ramAddr;
    logic [31:0]           ramWData;
    logic [3:0]            ramByteEn;
    logic [31:0]           ramRData;

    logic                  starveActive;

    // Environment side: requesters plus the RAM backend.
    modport master (
        output coreReq, coreWrite, coreAddr, coreWData, coreByteEn,
        input  coreGrant, coreStall, coreRValid, coreRData,
        output dbgReq, dbgWrite, dbgAddr, dbgWData, dbgByteEn,
        input  dbgGrant, dbgRValid, dbgRData,
        input  ramEnable, ramWrite, ramAddr, ramWData, ramByteEn,
        output ramRData,
        input  starveActive
    );

    // Arbiter side.
    modport slave (
        input  coreReq, coreWrite, coreAddr, coreWData, coreByteEn,
        output coreGrant, coreStall, coreRValid, coreRData,
        input  dbgReq, dbgWrite, dbgAddr, dbgWData, dbgByteEn,
        output dbgGrant, dbgRValid, dbgRData,
        output ramEnable, ramWrite, ramAddr, ramWData, ramByteEn,
        input  ramRData,
        output starveActive
    );
endinterface

`default_nettype wire

// File: rtl/jzjpcc_mem_arbiter.sv
// ============================================================================
// Module   : jzjpcc_mem_arbiter
// Brief    : Core/debug arbiter for the single-word RAM data port with debug
//            starvation override; optional grant statistics via the macro
//            JZJPCC_MEM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jzjpcc_mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WAIT   = 4
) (
    input  wire logic           clock,
    input  wire logic           reset,
    jzjpcc_mem_arbiter_if.slave bus
`ifdef JZJPCC_MEM_ARB_STATS_EN
    ,
    output logic [15:0]         coreGrantCount,
    output logic [15:0]         dbgGrantCount,
    output logic [15:0]         stallCount
`endif
);

    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CORE = 2'd1,
        RD_DBG  = 2'd2
    } rd_owner_t;

    rd_owner_t             r_rd_owner;
    logic [3:0]            r_wait_count;

    logic                  w_core_req;
    logic                  w_dbg_req;
    logic                  w_starve;
    logic                  w_core_grant;
    logic                  w_dbg_grant;
    logic                  w_ram_write;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [31:0]           w_ram_wdata;
    logic [3:0]            w_ram_byte_en;

    // Requests are masked while reset is held so every output reads zero.
    assign w_core_req   = bus.coreReq & reset;
    assign w_dbg_req    = bus.dbgReq & reset;
    assign w_starve     = w_dbg_req & (r_wait_count == c_MAX_WAIT);
    assign w_dbg_grant  = w_dbg_req & (~w_core_req | w_starve);
    assign w_core_grant = w_core_req & ~w_dbg_grant;

    always_comb begin
        w_ram_write   = 1'b0;
        w_ram_addr    = '0;
        w_ram_wdata   = '0;
        w_ram_byte_en = 4'b0000;
        if (w_dbg_grant) begin
            w_ram_write   = bus.dbgWrite;
            w_ram_addr    = bus.dbgAddr;
            w_ram_wdata   = bus.dbgWData;
            w_ram_byte_en = bus.dbgWrite ? bus.dbgByteEn : 4'b1111;
        end else if (w_core_grant) begin
            w_ram_write   = bus.coreWrite;
            w_ram_addr    = bus.coreAddr;
            w_ram_wdata   = bus.coreWData;
            w_ram_byte_en = bus.coreWrite ? bus.coreByteEn : 4'b1111;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait_count <= 4'd0;
            r_rd_owner   <= RD_NONE;
        end else begin
            if (!w_dbg_req || w_dbg_grant) begin
                r_wait_count <= 4'd0;
            end else if (r_wait_count != c_MAX_WAIT) begin
                r_wait_count <= r_wait_count + 4'd1;
            end

            // Track who owns the read data that the RAM returns next cycle.
            if (w_core_grant && !bus.coreWrite) begin
                r_rd_owner <= RD_CORE;
            end else if (w_dbg_grant && !bus.dbgWrite) begin
                r_rd_owner <= RD_DBG;
            end else begin
                r_rd_owner <= RD_NONE;
            end
        end
    end

    assign bus.coreGrant    = w_core_grant;
    assign bus.dbgGrant     = w_dbg_grant;
    assign bus.coreStall    = w_core_req & ~w_core_grant;
    assign bus.starveActive = w_starve;

    assign bus.ramEnable    = w_core_grant | w_dbg_grant;
    assign bus.ramWrite     = w_ram_write;
    assign bus.ramAddr      = w_ram_addr;
    assign bus.ramWData     = w_ram_wdata;
    assign bus.ramByteEn    = w_ram_byte_en;

    assign bus.coreRValid   = (r_rd_owner == RD_CORE);
    assign bus.dbgRValid    = (r_rd_owner == RD_DBG);
    assign bus.coreRData    = (r_rd_owner == RD_CORE) ? bus.ramRData : 32'd0;
    assign bus.dbgRData     = (r_rd_owner == RD_DBG)  ? bus.ramRData : 32'd0;

`ifdef JZJPCC_MEM_ARB_STATS_EN
    logic [15:0] r_core_grant_count;
    logic [15:0] r_dbg_grant_count;
    logic [15:0] r_stall_count;

    // Free-running counters; natural 16-bit wraparound is intended.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_core_grant_count <= 16'd0;
            r_dbg_grant_count  <= 16'd0;
            r_stall_count      <= 16'd0;
        end else begin
            if (w_core_grant) begin
                r_core_grant_count <= r_core_grant_count + 16'd1;
            end
            if (w_dbg_grant) begin
                r_dbg_grant_count <= r_dbg_grant_count + 16'd1;
            end
            if (w_core_req && !w_core_grant) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign coreGrantCount = r_core_grant_count;
    assign dbgGrantCount  = r_dbg_grant_count;
    assign stallCount     = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jzjpcc_mem_arbiter.sv
// ============================================================================
// Module   : tb_jzjpcc_mem_arbiter
// Brief    : Self-checking bench for jzjpcc_mem_arbiter with a read-owner
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jzjpcc_mem_arbiter;
    localparam int ADDR_WIDTH = 12;
    localparam int MAX_WAIT   = 4;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CORE = 2'd1;
    localparam logic [1:0] OWN_DBG  = 2'd2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic [1:0] exp_q[$];

    jzjpcc_mem_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

`ifdef JZJPCC_MEM_ARB_STATS_EN
    logic [15:0] coreGrantCount;
    logic [15:0] dbgGrantCount;
    logic [15:0] stallCount;
`endif

    jzjpcc_mem_arbiter #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus)
`ifdef JZJPCC_MEM_ARB_STATS_EN
        ,
        .coreGrantCount(coreGrantCount),
        .dbgGrantCount (dbgGrantCount),
        .stallCount    (stallCount)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_core(input logic req, input logic wr, input logic [ADDR_WIDTH-1:0] addr,
                              input logic [31:0] wd, input logic [3:0] be);
        bus.coreReq = req; bus.coreWrite = wr; bus.coreAddr = addr;
        bus.coreWData = wd; bus.coreByteEn = be;
    endtask

    task automatic drive_dbg(input logic req, input logic wr, input logic [ADDR_WIDTH-1:0] addr,
                             input logic [31:0] wd, input logic [3:0] be);
        bus.dbgReq = req; bus.dbgWrite = wr; bus.dbgAddr = addr;
        bus.dbgWData = wd; bus.dbgByteEn = be;
    endtask

    task automatic idle();
        drive_core(1'b0, 1'b0, '0, 32'd0, 4'd0);
        drive_dbg(1'b0, 1'b0, '0, 32'd0, 4'd0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_core(1'b1, 1'b0, 12'h010, 32'hA5A5A5A5, 4'hF);
        drive_dbg(1'b1, 1'b1, 12'h020, 32'h5A5A5A5A, 4'h3);
        bus.ramRData = 32'hFFFFFFFF;
        repeat (2) step();
        #3;
        tests_run++;
        if ({bus.coreGrant, bus.dbgGrant, bus.coreStall, bus.starveActive, bus.ramEnable, bus.ramWrite} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.coreGrant, bus.dbgGrant, bus.coreStall, bus.starveActive, bus.ramEnable, bus.ramWrite});
        end
        tests_run++;
        if ({bus.coreRValid, bus.dbgRValid, bus.coreRData, bus.dbgRData} !== 66'd0) begin
            tests_failed++;
            $display("FAIL reset_rvalid: got %b/%b %h/%h expected 0/0 0/0",
                     bus.coreRValid, bus.dbgRValid, bus.coreRData, bus.dbgRData);
        end
        tests_run++;
        if ({bus.ramAddr, bus.ramWData, bus.ramByteEn} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ram_bus: got %h %h %h expected 0 0 0", bus.ramAddr, bus.ramWData, bus.ramByteEn);
        end
        step();
        reset = 1'b1;
        idle();
        bus.ramRData = 32'd0;
    endtask

    task automatic test_core_read();
        logic [1:0] own;
        step();
        drive_core(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        #3;
        tests_run++;
        if ({bus.coreGrant, bus.dbgGrant, bus.ramEnable, bus.ramWrite, bus.ramAddr, bus.ramByteEn} !== {4'b1010, 12'h010, 4'hF}) begin
            tests_failed++;
            $display("FAIL core_read_grant: got %b%b%b%b addr=%h be=%h expected 1010 addr=010 be=f",
                     bus.coreGrant, bus.dbgGrant, bus.ramEnable, bus.ramWrite, bus.ramAddr, bus.ramByteEn);
        end
        exp_q.push_back(OWN_CORE);
        step();
        idle();
        bus.ramRData = 32'hDEADBEEF;
        #3;
        own = exp_q.pop_front();
        tests_run++;
        if ({bus.coreRValid, bus.dbgRValid, bus.coreRData} !== {own == OWN_CORE, own == OWN_DBG, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL core_read_return: got cv=%b dv=%b data=%h expected cv=1 dv=0 data=deadbeef",
                     bus.coreRValid, bus.dbgRValid, bus.coreRData);
        end
    endtask

    task automatic test_contention();
        logic exp_d;
        step();
        idle();
        for (int i = 0; i < 10; i++) begin
            step();
            drive_core(1'b1, 1'b1, 12'h100, 32'h11111111, 4'hF);
            drive_dbg(1'b1, 1'b1, 12'h200, 32'h22222222, 4'hF);
            #3;
            exp_d = (i % 5 == 4);
            tests_run++;
            if ({bus.coreGrant, bus.dbgGrant, bus.starveActive, bus.coreStall} !== {~exp_d, exp_d, exp_d, exp_d}) begin
                tests_failed++;
                $display("FAIL contention_c%0d: got cg,dg,sa,st=%b%b%b%b expected %b%b%b%b", i,
                         bus.coreGrant, bus.dbgGrant, bus.starveActive, bus.coreStall, ~exp_d, exp_d, exp_d, exp_d);
            end
            tests_run++;
            if (bus.ramAddr !== (exp_d ? 12'h200 : 12'h100)) begin
                tests_failed++;
                $display("FAIL contention_addr_c%0d: got %h expected %h", i, bus.ramAddr, exp_d ? 12'h200 : 12'h100);
            end
        end
    endtask

    task automatic test_abandon();
        logic exp_d;
        step();
        idle();
        for (int i = 0; i < 9; i++) begin
            step();
            drive_core(1'b1, 1'b1, 12'h101, 32'h0, 4'hF);
            drive_dbg(i != 3, 1'b1, 12'h201, 32'h0, 4'hF);
            #3;
            exp_d = (i == 8);
            tests_run++;
            if ({bus.coreGrant, bus.dbgGrant, bus.starveActive} !== {~exp_d, exp_d, exp_d}) begin
                tests_failed++;
                $display("FAIL abandon_c%0d: got cg,dg,sa=%b%b%b expected %b%b%b", i,
                         bus.coreGrant, bus.dbgGrant, bus.starveActive, ~exp_d, exp_d, exp_d);
            end
        end
    endtask

    task automatic test_dbg_write();
        step();
        idle();
        drive_dbg(1'b1, 1'b1, 12'h3FF, 32'h12345678, 4'b0011);
        #3;
        tests_run++;
        if ({bus.coreGrant, bus.dbgGrant, bus.ramEnable, bus.ramWrite, bus.ramAddr, bus.ramWData, bus.ramByteEn}
                !== {4'b0111, 12'h3FF, 32'h12345678, 4'b0011}) begin
            tests_failed++;
            $display("FAIL dbg_write: got cg%b dg%b en%b wr%b a=%h d=%h be=%b expected 0111 3ff 12345678 0011",
                     bus.coreGrant, bus.dbgGrant, bus.ramEnable, bus.ramWrite, bus.ramAddr, bus.ramWData, bus.ramByteEn);
        end
        step();
        idle();
        bus.ramRData = 32'h87654321;
        #3;
        tests_run++;
        if ({bus.coreRValid, bus.dbgRValid, bus.dbgRData} !== 34'd0) begin
            tests_failed++;
            $display("FAIL dbg_write_no_rvalid: got cv=%b dv=%b d=%h expected 0 0 0",
                     bus.coreRValid, bus.dbgRValid, bus.dbgRData);
        end
    endtask

    task automatic test_interleaved();
        logic [1:0]  own;
        logic [31:0] rd [3];
        rd[0] = 32'h0; rd[1] = 32'h11112222; rd[2] = 32'h33334444;
        step();
        idle();
        for (int c = 0; c < 3; c++) begin
            step();
            idle();
            if (c == 0) drive_core(1'b1, 1'b0, 12'h011, 32'h0, 4'h0);
            if (c == 1) drive_dbg(1'b1, 1'b0, 12'h022, 32'h0, 4'h0);
            bus.ramRData = rd[c];
            #3;
            own = (exp_q.size() > 0) ? exp_q.pop_front() : OWN_NONE;
            tests_run++;
            if ({bus.coreRValid, bus.dbgRValid, bus.coreRData, bus.dbgRData}
                    !== {own == OWN_CORE, own == OWN_DBG, (own == OWN_CORE) ? rd[c] : 32'd0,
                         (own == OWN_DBG) ? rd[c] : 32'd0}) begin
                tests_failed++;
                $display("FAIL interleaved_c%0d: got cv=%b dv=%b cd=%h dd=%h expected owner=%0d data=%h", c,
                         bus.coreRValid, bus.dbgRValid, bus.coreRData, bus.dbgRData, own, rd[c]);
            end
            if (c == 0) exp_q.push_back(OWN_CORE);
            if (c == 1) exp_q.push_back(OWN_DBG);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  own;
        logic [31:0] rdata;
        int          sel;
        for (int c = 0; c < 17; c++) begin
            step();
            idle();
            rdata = $urandom;
            bus.ramRData = rdata;
            sel = (c == 16) ? 0 : $urandom_range(1, 4);
            case (sel)
                1: drive_core(1'b1, 1'b0, ADDR_WIDTH'(c), 32'h0, 4'h0);
                2: drive_dbg(1'b1, 1'b0, ADDR_WIDTH'(c + 100), 32'h0, 4'h0);
                3: drive_core(1'b1, 1'b1, ADDR_WIDTH'(c), 32'hABCD0000 + c, 4'h1);
                4: drive_dbg(1'b1, 1'b1, ADDR_WIDTH'(c), 32'h0, 4'h2);
                default: ;
            endcase
            #3;
            own = (exp_q.size() > 0) ? exp_q.pop_front() : OWN_NONE;
            tests_run++;
            if ({bus.coreRValid, bus.dbgRValid, bus.coreRData, bus.dbgRData}
                    !== {own == OWN_CORE, own == OWN_DBG, (own == OWN_CORE) ? rdata : 32'd0,
                         (own == OWN_DBG) ? rdata : 32'd0}) begin
                tests_failed++;
                $display("FAIL b2b_return_c%0d: got cv=%b dv=%b cd=%h dd=%h expected owner=%0d data=%h", c,
                         bus.coreRValid, bus.dbgRValid, bus.coreRData, bus.dbgRData, own, rdata);
            end
            tests_run++;
            if ({bus.coreGrant, bus.dbgGrant, bus.ramWrite} !== {sel == 1 || sel == 3, sel == 2 || sel == 4, sel == 3 || sel == 4}) begin
                tests_failed++;
                $display("FAIL b2b_grant_c%0d: got cg,dg,wr=%b%b%b expected sel=%0d", c,
                         bus.coreGrant, bus.dbgGrant, bus.ramWrite, sel);
            end
            exp_q.push_back(sel == 1 ? OWN_CORE : (sel == 2 ? OWN_DBG : OWN_NONE));
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_read();
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            drive_core(1'b1, 1'b1, 12'h055, 32'h0, 4'hF);
            drive_dbg(1'b1, 1'b1, 12'h066, 32'h0, 4'hF);
        end
        step();
        drive_core(1'b1, 1'b0, 12'h055, 32'h0, 4'h0);
        #3;
        tests_run++;
        if ({bus.coreGrant, bus.dbgGrant} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rst_mid_grant: got cg,dg=%b%b expected 10", bus.coreGrant, bus.dbgGrant);
        end
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if ({bus.coreGrant, bus.dbgGrant, bus.ramEnable} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got cg,dg,en=%b%b%b expected 000", bus.coreGrant, bus.dbgGrant, bus.ramEnable);
        end
        for (int c = 1; c < 7; c++) begin
            step();
            bus.ramRData = 32'hCAFEF00D;
            if (c == 2) begin
                reset = 1'b1;
                drive_core(1'b1, 1'b1, 12'h055, 32'h0, 4'hF);
                drive_dbg(1'b1, 1'b1, 12'h066, 32'h0, 4'hF);
            end
            #3;
            tests_run++;
            if ({bus.coreRValid, bus.coreRData} !== 33'd0) begin
                tests_failed++;
                $display("FAIL rst_mid_rvalid_c%0d: got cv=%b d=%h expected 0 0", c, bus.coreRValid, bus.coreRData);
            end
            if (c >= 2) begin
                tests_run++;
                if (bus.dbgGrant !== (c == 6)) begin
                    tests_failed++;
                    $display("FAIL rst_mid_wait_c%0d: got dg=%b expected %b", c, bus.dbgGrant, c == 6);
                end
            end
        end
        step();
        idle();
    endtask

`ifdef JZJPCC_MEM_ARB_STATS_EN
    task automatic test_stats();
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive_core(1'b1, 1'b1, 12'h001, 32'h0, 4'hF);
        repeat (70000) step();
        idle();
        step();
        tests_run++;
        if ({coreGrantCount, dbgGrantCount, stallCount} !== {16'd4464, 16'd0, 16'd0}) begin
            tests_failed++;
            $display("FAIL stats_wrap: got %0d/%0d/%0d expected 4464/0/0", coreGrantCount, dbgGrantCount, stallCount);
        end
    endtask
`endif

    initial begin
        idle();
        bus.ramRData = 32'd0;
        test_reset();
        test_core_read();
        test_contention();
        test_abandon();
        test_dbg_write();
        test_interleaved();
        test_back_to_back();
        test_reset_mid_read();
`ifdef JZJPCC_MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jzjpcc_mem_arbiter.md
Name: jzjpcc_mem_arbiter

Overview:
- Shares the single word-wide data port of the memory backend between two requesters: the core's memory stage and an external debug/DMA requester.
- Grants at most one access per cycle, with the core at fixed priority.
- A debug starvation counter forces a debug grant after a bounded wait.
- Read data is returned one cycle after grant, routed to the requester that owns the access.
- Sits between the memory stage / hazard unit and the memory backend data interface.

Parameters:
- ADDR_WIDTH, 12: word-address width of the RAM port (bits [ADDR_WIDTH+1:2] of the byte address).
- MAX_WAIT, 4: number of consecutive denied debug cycles after which debug wins. Legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- coreReq  in  1  core access request.
- coreWrite  in  1  1 = write, 0 = read.
- coreAddr  in  ADDR_WIDTH  word address.
- coreWData  in  32  write data.
- coreByteEn  in  4  byte enables for a write.
- coreGrant  out  1  core access accepted this cycle.
- coreStall  out  1  coreReq & ~coreGrant; feeds the hazard unit.
- coreRValid  out  1  core read data valid.
- coreRData  out  32  core read data.
- dbgReq, dbgWrite, dbgAddr, dbgWData, dbgByteEn  in  1/1/ADDR_WIDTH/32/4  debug request bundle, same meaning as core.
- dbgGrant  out  1  debug access accepted this cycle.
- dbgRValid  out  1  debug read data valid.
- dbgRData  out  32  debug read data.
- ramEnable  out  1  RAM access this cycle.
- ramWrite  out  1  write strobe.
- ramAddr  out  ADDR_WIDTH  word address.
- ramWData  out  32  write data.
- ramByteEn  out  4  byte enables.
- ramRData  in  32  RAM read data, valid the cycle after a read strobe.
- starveActive  out  1  debug priority override in effect this cycle.

Behaviour:
- Reset (reset = 0, asynchronous): waitCount = 0, rdOwner = NONE. All registered outputs are 0. Combinational outputs evaluate to 0 because requests are ignored while in reset.
- Arbitration is combinational, in the same cycle as the request:
  - starveActive = dbgReq & (waitCount == MAX_WAIT).
  - dbgGrant = dbgReq & (~coreReq | starveActive).
  - coreGrant = coreReq & ~dbgGrant.
  - Grants are one-hot or zero; never both.
- RAM mux: ramEnable = coreGrant | dbgGrant. ramWrite, ramAddr, ramWData and ramByteEn come from the granted requester. With no grant, all are 0.
- ramByteEn is forced to 4'b1111 on reads; byte enables are meaningful only for writes.
- Requester rule: req and its payload must stay stable until the cycle its grant is high. The arbiter does not latch payloads. A requester may drop req without a grant (abandon); this is legal.
- waitCount, updated on posedge:
  - cleared when dbgGrant or ~dbgReq;
  - otherwise incremented, saturating at MAX_WAIT.
  - After a starved grant it returns to 0, so the core regains priority.
- Read return tracking, a 2-bit register rdOwner ∈ {NONE, CORE, DBG}:
  - Set on posedge to the owner of a granted read (~ramWrite); set to NONE for writes or idle.
  - coreRValid = (rdOwner == CORE); dbgRValid = (rdOwner == DBG).
  - coreRData/dbgRData = ramRData when the matching valid is high, else 0.
  - Latency: grant in cycle N → RValid and data in cycle N+1.
  - Back-to-back reads, interleaved between requesters, are fully pipelined, one per cycle.
- Simultaneous requests:
  - core wins unless starveActive;
  - with MAX_WAIT = 4, continuous contention gives the pattern C,C,C,C,D repeating.
- Write followed by read to the same address in consecutive cycles: the read returns the new data. This relies on the backend's write-then-read ordering; the arbiter adds no forwarding.
- Reset asserted mid-read: the pending rdOwner is discarded and no RValid is produced after reset releases.

Optional Feature:
- Macro: JZJPCC_MEM_ARB_STATS_EN.
- Defined: adds three 16-bit output counters:
  - coreGrantCount: increments on coreGrant;
  - dbgGrantCount: increments on dbgGrant;
  - stallCount: increments on coreStall.
  - All counters wrap from 16'hFFFF to 0, reset to 0, and increment in the same posedge as their event.
- Not defined: the ports and counter logic are absent. Arbitration behaviour is identical in both builds.

Test Plan:
- Core-only read: coreReq=1, addr 0x010 for 1 cycle; ramRData=0xDEADBEEF next cycle → coreGrant=1 in cycle 0; coreRValid=1, coreRData=0xDEADBEEF in cycle 1; dbgRValid=0.
- Contention, MAX_WAIT=4: coreReq and dbgReq held high for 10 cycles → grants C,C,C,C,D,C,C,C,C,D; starveActive high exactly in cycles 4 and 9; coreStall high in cycles 4 and 9.
- Debug write while core idle: dbgReq=1, dbgWrite=1, addr 0x3FF, data 0x12345678, byteEn 4'b0011 → same-cycle dbgGrant; ramWrite=1, ramByteEn=4'b0011; no RValid next cycle.
- Interleaved reads: core reads in cycle 0, debug reads in cycle 1 → coreRValid in cycle 1 and dbgRValid in cycle 2, each carrying that cycle's ramRData.
- Reset mid-read: core read granted in cycle 0; reset=0 asynchronously during cycle 0; release in cycle 2 → no coreRValid in any cycle; waitCount=0.
- Stats build: 70000 core grants → coreGrantCount = 70000 mod 65536 = 4464; with the macro undefined, the build elaborates without the counter ports.
